// File: rtl/cpu_subsys_sram_arbiter.sv
// Two-port valid/ready arbiter sharing the cpu_subsys_sram port; ownership is held for a whole transaction.
// Define CPU_SUBSYS_SRAM_ARB_RR_EN for round-robin ties; otherwise port 0 has fixed priority.
module cpu_subsys_sram_arbiter (
  input  logic        sys_clk,
  input  logic        rst,
  input  logic        s0_mem_valid,
  input  logic [29:0] s0_mem_addr,
  input  logic        s0_mem_write,
  input  logic [31:0] s0_mem_wdata,
  input  logic [3:0]  s0_mem_wstrb,
  output logic [31:0] s0_mem_rdata,
  output logic        s0_mem_ready,
  input  logic        s1_mem_valid,
  input  logic [29:0] s1_mem_addr,
  input  logic        s1_mem_write,
  input  logic [31:0] s1_mem_wdata,
  input  logic [3:0]  s1_mem_wstrb,
  output logic [31:0] s1_mem_rdata,
  output logic        s1_mem_ready,
  output logic        m_mem_valid,
  output logic [29:0] m_mem_addr,
  output logic        m_mem_write,
  output logic [31:0] m_mem_wdata,
  output logic [3:0]  m_mem_wstrb,
  input  logic [31:0] m_mem_rdata,
  input  logic        m_mem_ready,
  output logic        arb_busy,
  output logic        arb_owner
);
  typedef enum logic {IDLE, BUSY} state_t;

  state_t state, state_nx;
  logic   owner, owner_nx;
  logic   last_grant, last_grant_nx;
  logic   sel, grant, tie_pick;

`ifdef CPU_SUBSYS_SRAM_ARB_RR_EN
  assign tie_pick = ~last_grant;
`else
  assign tie_pick = 1'b0;
`endif

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      state      <= state_nx;
      owner      <= owner_nx;
      last_grant <= last_grant_nx;
    end
  end

  always_comb begin
    state_nx      = state;
    owner_nx      = owner;
    last_grant_nx = last_grant;
    sel           = owner;
    grant         = 1'b0;
    case (state)
      IDLE: begin
        if (s0_mem_valid && s1_mem_valid) begin
          sel   = tie_pick;
          grant = 1'b1;
        end else if (s0_mem_valid) begin
          sel   = 1'b0;
          grant = 1'b1;
        end else if (s1_mem_valid) begin
          sel   = 1'b1;
          grant = 1'b1;
        end
        if (grant) begin
          owner_nx = sel;
          if (!m_mem_ready) state_nx = BUSY;
        end
      end
      BUSY: begin
        // Only the owner is looked at; a dropped valid abandons the lock.
        sel   = owner;
        grant = owner ? s1_mem_valid : s0_mem_valid;
        if (!grant || m_mem_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    if (grant && m_mem_ready) last_grant_nx = sel;
  end

  assign m_mem_valid  = grant & ~rst;
  assign m_mem_addr   = sel ? s1_mem_addr  : s0_mem_addr;
  assign m_mem_write  = sel ? s1_mem_write : s0_mem_write;
  assign m_mem_wdata  = sel ? s1_mem_wdata : s0_mem_wdata;
  assign m_mem_wstrb  = sel ? s1_mem_wstrb : s0_mem_wstrb;

  assign s0_mem_ready = m_mem_valid & m_mem_ready & ~sel;
  assign s1_mem_ready = m_mem_valid & m_mem_ready & sel;
  assign s0_mem_rdata = (m_mem_valid && !sel) ? m_mem_rdata : 32'h0;
  assign s1_mem_rdata = (m_mem_valid && sel)  ? m_mem_rdata : 32'h0;

  assign arb_busy  = (state == BUSY);
  assign arb_owner = owner;
endmodule

// File: tb/tb_cpu_subsys_sram_arbiter.sv
// Directed bench: per-cycle check against a lock/last-grant arbitration model plus literal expectations.
module tb_cpu_subsys_sram_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  s_valid, s_write;
  logic [29:0] s_addr  [2];
  logic [31:0] s_wdata [2];
  logic [3:0]  s_wstrb [2];
  logic [31:0] s_rdata0, s_rdata1;
  logic        s_ready0, s_ready1;
  logic        m_valid, m_write, m_ready;
  logic [29:0] m_addr;
  logic [31:0] m_wdata, m_rdata;
  logic [3:0]  m_wstrb;
  logic        arb_busy, arb_owner;

  int errors = 0, checks = 0;
  int cyc = 0;

  // SRAM model: ready after lat cycles of a held request (lat 0 = same cycle).
  logic [7:0]  lat, cnt;
  logic [31:0] rd_base;
  assign m_ready = m_valid && (cnt == lat);
  assign m_rdata = rd_base ^ {2'b0, m_addr};

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!m_valid || m_ready) cnt <= 8'd0;
    else cnt <= cnt + 8'd1;
  end

  cpu_subsys_sram_arbiter dut (
    .sys_clk(clk), .rst(rst),
    .s0_mem_valid(s_valid[0]), .s0_mem_addr(s_addr[0]), .s0_mem_write(s_write[0]),
    .s0_mem_wdata(s_wdata[0]), .s0_mem_wstrb(s_wstrb[0]),
    .s0_mem_rdata(s_rdata0), .s0_mem_ready(s_ready0),
    .s1_mem_valid(s_valid[1]), .s1_mem_addr(s_addr[1]), .s1_mem_write(s_write[1]),
    .s1_mem_wdata(s_wdata[1]), .s1_mem_wstrb(s_wstrb[1]),
    .s1_mem_rdata(s_rdata1), .s1_mem_ready(s_ready1),
    .m_mem_valid(m_valid), .m_mem_addr(m_addr), .m_mem_write(m_write),
    .m_mem_wdata(m_wdata), .m_mem_wstrb(m_wstrb),
    .m_mem_rdata(m_rdata), .m_mem_ready(m_ready),
    .arb_busy(arb_busy), .arb_owner(arb_owner)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: a locked port (or none) plus the last completing port.
  bit m_locked = 0;
  int m_lock_p = 0;
  int m_last   = 1;
  int cur_g    = -1;
  bit cur_rdy  = 0;
  int order_m[$];
  int order_d[$];
  int n_ready0 = 0, n_ready1 = 0;
  int r0cyc = -1, g1cyc = -1;
  bit busy_seen = 0;
  logic [31:0] last_rdata [2];

  always @(negedge clk) begin
    int g;
    if (rst) g = -1;
    else if (m_locked) g = s_valid[m_lock_p] ? m_lock_p : -1;
    else if (s_valid[0] && s_valid[1]) begin
`ifdef CPU_SUBSYS_SRAM_ARB_RR_EN
      g = (m_last == 0) ? 1 : 0;
`else
      g = 0;
`endif
    end
    else if (s_valid[0]) g = 0;
    else if (s_valid[1]) g = 1;
    else g = -1;
    check("m_valid", m_valid, g >= 0);
    if (g >= 0) begin
      check("m_addr",  m_addr,  s_addr[g]);
      check("m_write", m_write, s_write[g]);
      check("m_wdata", m_wdata, s_wdata[g]);
      check("m_wstrb", m_wstrb, s_wstrb[g]);
    end
    check("s0_ready", s_ready0, (g == 0) && m_ready);
    check("s1_ready", s_ready1, (g == 1) && m_ready);
    check("s0_rdata", s_rdata0, (g == 0) ? m_rdata : 32'h0);
    check("s1_rdata", s_rdata1, (g == 1) ? m_rdata : 32'h0);
    check("arb_busy", arb_busy, !rst && m_locked);
    cur_g   = g;
    cur_rdy = m_ready;
    if (s_ready0) begin n_ready0++; order_d.push_back(0); r0cyc = cyc; end
    if (s_ready1) begin n_ready1++; order_d.push_back(1); end
    if (m_valid && m_addr == 30'h400 && g1cyc < 0) g1cyc = cyc;
    if (arb_busy) busy_seen = 1;
  end

  always @(posedge clk) begin
    if (rst) begin
      m_locked = 0;
      m_last   = 1;
    end else if (cur_g >= 0) begin
      if (cur_rdy) begin
        m_locked = 0;
        m_last   = cur_g;
        order_m.push_back(cur_g);
      end else begin
        m_locked = 1;
        m_lock_p = cur_g;
      end
    end else m_locked = 0;
  end

  task automatic wait_ready(input int p);
    int t = 0;
    @(negedge clk);
    while (!(p ? s_ready1 : s_ready0) && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!(p ? s_ready1 : s_ready0)) begin
      checks++;
      errors++;
      $display("FAIL timeout port%0d: got no ready expected ready within 200 cycles", p);
    end
  endtask

  task automatic xfer(input int p, input int n, input logic [29:0] base, input logic wr);
    for (int i = 0; i < n; i++) begin
      s_valid[p] = 1'b1;
      s_addr[p]  = base + 30'(i);
      s_write[p] = wr;
      s_wdata[p] = {2'b0, base} ^ (32'(i) * 32'h1111);
      s_wstrb[p] = 4'hF >> (i % 4);
      wait_ready(p);
      last_rdata[p] = p ? s_rdata1 : s_rdata0;
      @(posedge clk); #1;
    end
    s_valid[p] = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  int exp_order[8];
  int t0;

  initial begin
    rst = 1'b1;
    s_valid = 2'b00; s_write = 2'b00;
    for (int i = 0; i < 2; i++) begin
      s_addr[i] = '0; s_wdata[i] = '0; s_wstrb[i] = '0; last_rdata[i] = '0;
    end
    lat = 8'd1; rd_base = 32'hC0DE0000;
    repeat (2) @(posedge clk); #1;
    check("reset_owner", arb_owner, 1'b0);
    check("reset_busy", arb_busy, 1'b0);
    check("reset_mvalid", m_valid, 1'b0);
    rst = 1'b0;

    // Single port 0 read with 2-cycle SRAM latency
    lat = 8'd2; rd_base = 32'hDEADBEEF ^ 32'h10;
    n_ready0 = 0; n_ready1 = 0;
    xfer(0, 1, 30'h10, 1'b0);
    check("t1_rdata", last_rdata[0], 32'hDEADBEEF);
    check("t1_ready0_cnt", n_ready0, 1);
    check("t1_ready1_cnt", n_ready1, 0);
    rd_base = 32'hC0DE0000;

    // Port 1 write forwarded unchanged, busy from cycle 1
    lat = 8'd3;
    s_valid[1] = 1'b1; s_addr[1] = 30'h20; s_write[1] = 1'b1;
    s_wdata[1] = 32'h12345678; s_wstrb[1] = 4'b0011;
    @(negedge clk);
    check("t2_addr", m_addr, 30'h20);
    check("t2_wdata", m_wdata, 32'h12345678);
    check("t2_wstrb", m_wstrb, 4'b0011);
    check("t2_write", m_write, 1'b1);
    check("t2_busy_c0", arb_busy, 1'b0);
    @(negedge clk);
    check("t2_busy_c1", arb_busy, 1'b1);
    check("t2_owner", arb_owner, 1'b1);
    @(negedge clk);
    @(negedge clk);
    check("t2_ready", s_ready1, 1'b1);
    check("t2_busy_rdy", arb_busy, 1'b1);
    @(posedge clk); #1;
    s_valid[1] = 1'b0;
    @(negedge clk);
    check("t2_busy_after", arb_busy, 1'b0);
    @(posedge clk); #1;

    // Both ports, 4 transactions each, from reset
    do_reset();
    lat = 8'd1;
    order_d.delete(); order_m.delete();
    fork
      xfer(0, 4, 30'h100, 1'b0);
      xfer(1, 4, 30'h200, 1'b1);
    join
`ifdef CPU_SUBSYS_SRAM_ARB_RR_EN
    exp_order = '{0, 1, 0, 1, 0, 1, 0, 1};
`else
    exp_order = '{0, 0, 0, 0, 1, 1, 1, 1};
`endif
    check("t3_count", order_d.size(), 8);
    check("t3_model_count", order_m.size(), 8);
    for (int i = 0; i < 8; i++) begin
      if (i < order_d.size()) check($sformatf("t3_order%0d", i), order_d[i], exp_order[i]);
      if (i < order_m.size()) check($sformatf("t3_model%0d", i), order_m[i], exp_order[i]);
    end

    // Port 1 arrives while port 0 holds a 5-cycle transaction
    lat = 8'd5; g1cyc = -1; r0cyc = -1;
    fork
      xfer(0, 1, 30'h300, 1'b0);
      begin
        repeat (2) @(posedge clk); #1;
        xfer(1, 1, 30'h400, 1'b1);
      end
    join
    check("t4_p1_after_p0", g1cyc, r0cyc + 1);

    // Zero-wait SRAM, back-to-back port 0
    lat = 8'd0; busy_seen = 0; n_ready0 = 0;
    t0 = cyc;
    xfer(0, 4, 30'h500, 1'b0);
    check("t5_cycles", cyc - t0, 4);
    check("t5_completions", n_ready0, 4);
    check("t5_never_busy", busy_seen, 1'b0);

    // Reset in the middle of a BUSY transaction
    lat = 8'd5;
    s_valid[0] = 1'b1; s_addr[0] = 30'h550; s_write[0] = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("t6_mvalid", m_valid, 1'b0);
    check("t6_ready0", s_ready0, 1'b0);
    check("t6_ready1", s_ready1, 1'b0);
    check("t6_busy", arb_busy, 1'b0);
    check("t6_owner", arb_owner, 1'b0);
    s_addr[0] = 30'h600;
    s_valid[1] = 1'b1; s_addr[1] = 30'h700; s_write[1] = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("t6_tie_valid", m_valid, 1'b1);
    check("t6_tie_port0", m_addr, 30'h600);
    wait_ready(0);
    @(posedge clk); #1;
    s_valid[0] = 1'b0;
    wait_ready(1);
    @(posedge clk); #1;
    s_valid[1] = 1'b0;
    repeat (2) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
